serial_frame_capture: RTL and testbench
=======================================

Name: serial_frame_capture

Overview:
- Downstream consumer of the shift-pulse generator. Samples the serial input line on each RShift pulse and assembles a start/data/stop frame.
- When the generator's state output returns to idle, the block checks the frame and presents the data byte to the calculator's input logic through a valid/ack holding register.
- Tracks framing errors and overruns.

Parameters:
- FRAME_BITS, 10, total bits per frame: 1 start + DATA_BITS + 1 stop.
- DATA_BITS, 8, payload width. Must equal FRAME_BITS-2.
- ERRW, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_in  in  1  serial data line, already synchronised upstream.
- RShift  in  1  one-cycle shift pulse from the pulse generator.
- st  in  2  pulse-generator state: 00 idle, 01 armed, 10 shift, 11 wait.
- data_ack  in  1  consumer accepts data_out when data_valid=1.
- data_out  out  DATA_BITS  captured payload, LSB received first.
- data_valid  out  1  holding register full.
- frame_err  out  1  one-cycle pulse on a rejected frame.
- overrun  out  1  sticky; a good frame completed while data_valid=1 and not acked.
- err_count  out  ERRW  saturating count of rejected frames.
- busy  out  1  combinational; (st != 00).

Behaviour:
- Reset: all outputs, shift register, bit counter, st_q and length-error flag are cleared to 0. Reset takes priority over every other event, mid-frame included.
- st_q registers st every cycle.
- Frame-start event: st_q==00 and st==01. The shift register and bit counter are cleared to 0 on that edge. Any partial frame is discarded without an error.
- Shift: on an RShift=1 cycle with st!=00 and bit_cnt<FRAME_BITS:
  - shreg <= {rx_in, shreg[FRAME_BITS-1:1]} (right shift; new bit enters the MSB);
  - bit_cnt increments by 1.
  - After FRAME_BITS shifts: shreg[0]=start bit, shreg[FRAME_BITS-1]=stop bit, payload = shreg[FRAME_BITS-2:1].
- RShift=1 while bit_cnt==FRAME_BITS sets the length-error flag; shreg does not change. RShift while st==00 is ignored.
- Frame-done event: st_q==11 and st==00. On that edge the frame is good iff bit_cnt==FRAME_BITS, shreg[0]==0, shreg[FRAME_BITS-1]==1 and the length-error flag is clear.
  - Good frame: data_out <= payload; data_valid <= 1. If data_valid was already 1 and data_ack=0 that cycle, overrun <= 1 and the old data is overwritten (newest wins).
  - Bad frame: frame_err=1 for exactly one cycle; err_count increments and saturates at all-ones; data_out and data_valid are unchanged.
  - Latency: data_valid is visible on the first cycle after st is sampled as 00.
- Any transition into 00 other than from 11 (abort) is treated as a bad frame if bit_cnt!=0; otherwise it is ignored.
- Handshake: data_valid=1 and data_ack=1 clears data_valid on the next edge. data_out holds its value until the next good frame. data_ack with data_valid=0 has no effect.
- Good frame-done and data_ack in the same cycle: the ack consumes the old byte, the new byte loads, data_valid stays 1, and overrun is not set.
- overrun clears only on rst.
- bit_cnt is wide enough to hold FRAME_BITS and never wraps.

Test Plan:
- Good frame: rst, then st 00→01→10/11 cycling with 10 RShift pulses carrying rx_in = 0,1,0,1,0,0,1,0,1,1, then st 11→00 → data_out=0xA5, data_valid=1 one cycle later, frame_err=0, err_count=0.
- Ack then second frame: data_ack=1 for one cycle → data_valid=0. Send 0x3C → data_out=0x3C, data_valid=1, overrun=0.
- Bad stop bit: 0x5A frame with last bit 0 → frame_err pulses 1 cycle, err_count=1, data_valid and data_out unchanged.
- Overrun: two good frames 0x11 then 0x22 with no ack → data_out=0x22, overrun=1. A third frame with data_ack asserted in its done cycle → overrun stays 1, data_valid stays 1.
- Short frame and restart: 6 pulses, then st 11→00 → frame_err, err_count increments. A new st 00→01 mid-frame, then a full 0xFF frame → data_out=0xFF with no extra error.
- Reset mid-frame plus saturation: assert rst after 4 pulses → all outputs 0. Force 300 bad frames → err_count=0xFF.

Source files
------------

// File: rtl/serial_frame_capture.sv
// -----------------------------------------------------------------------------
// serial_frame_capture
//
// Purpose:
//   Samples the serial line on every RShift pulse from the shift-pulse
//   generator and assembles a start/data/stop frame. When the generator
//   returns to idle, the block checks the frame. A good frame loads its
//   payload into a valid/ack holding register for the calculator's input
//   logic. Rejected frames and overruns are reported.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset (clears all state)
//   rx_in       serial data line, already synchronised
//   RShift      one-cycle shift pulse from the pulse generator
//   st          generator state: 00 idle, 01 armed, 10 shift, 11 wait
//   data_ack    consumer takes data_out while data_valid=1
//   data_out    captured payload, LSB received first
//   data_valid  holding register full
//   frame_err   one-cycle pulse on a rejected frame
//   overrun     sticky: good frame arrived while an unacked byte was held
//   err_count   saturating count of rejected frames
//   busy        combinational, generator not idle
// -----------------------------------------------------------------------------
module serial_frame_capture #(
    parameter int FRAME_BITS = 10,
    parameter int DATA_BITS  = 8,   // must equal FRAME_BITS-2
    parameter int ERRW       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic                 RShift,
    input  logic [1:0]           st,
    input  logic                 data_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [ERRW-1:0]      err_count,
    output logic                 busy
);

    localparam int CNTW = $clog2(FRAME_BITS + 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FRAME_BITS);

    typedef enum logic [1:0] {
        GEN_IDLE  = 2'b00,
        GEN_ARMED = 2'b01,
        GEN_SHIFT = 2'b10,
        GEN_WAIT  = 2'b11
    } gen_st_t;

    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        return (&v) ? v : v + ERRW'(1);
    endfunction

    gen_st_t               st_q;
    logic [FRAME_BITS-1:0] shreg;
    logic [CNTW-1:0]       bit_cnt;
    logic                  len_err;

    logic frame_start;
    logic into_idle;
    logic frame_done;
    logic frame_abort;
    logic shift_en;
    logic len_over;
    logic frame_ok;
    logic good_frame;
    logic bad_frame;

    assign busy = (st != GEN_IDLE);

    // Event decode from the registered versus live generator state.
    assign frame_start = (st_q == GEN_IDLE) && (st == GEN_ARMED);
    assign into_idle   = (st_q != GEN_IDLE) && (st == GEN_IDLE);
    assign frame_done  = into_idle && (st_q == GEN_WAIT);
    assign frame_abort = into_idle && (st_q != GEN_WAIT);

    // Shifts stop once a full frame is held; any further pulse flags a
    // frame that was too long instead of corrupting the captured bits.
    assign shift_en = RShift && (st != GEN_IDLE) && (bit_cnt < FULL_CNT);
    assign len_over = RShift && (st != GEN_IDLE) && (bit_cnt == FULL_CNT);

    assign frame_ok = (bit_cnt == FULL_CNT) && !shreg[0]
                      && shreg[FRAME_BITS-1] && !len_err;

    assign good_frame = frame_done && frame_ok;
    // An abort with nothing captured yet is not counted as an error.
    assign bad_frame  = (frame_done && !frame_ok)
                        || (frame_abort && (bit_cnt != '0));

    // Capture: frame start discards any partial frame without an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= GEN_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            len_err <= 1'b0;
        end else begin
            st_q <= gen_st_t'(st);
            if (frame_start) begin
                shreg   <= '0;
                bit_cnt <= '0;
                len_err <= 1'b0;
            end else if (shift_en) begin
                shreg   <= {rx_in, shreg[FRAME_BITS-1:1]};
                bit_cnt <= bit_cnt + CNTW'(1);
            end else if (len_over) begin
                len_err <= 1'b1;
            end
        end
    end

    // Holding register and error reporting. A same-cycle ack consumes the
    // old byte, so a new byte loading alongside it is not an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            err_count  <= '0;
        end else begin
            frame_err <= bad_frame;
            if (bad_frame) begin
                err_count <= sat_inc(err_count);
            end
            if (good_frame) begin
                data_out   <= shreg[FRAME_BITS-2:1];
                data_valid <= 1'b1;
                if (data_valid && !data_ack) begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ack) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_capture.sv
module tb_serial_frame_capture;

    localparam int FB = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       RShift;
    logic [1:0] st;
    logic       data_ack;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic [7:0] err_count;
    logic       busy;

    serial_frame_capture #(.FRAME_BITS(10), .DATA_BITS(8), .ERRW(8)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .RShift(RShift), .st(st),
        .data_ack(data_ack), .data_out(data_out), .data_valid(data_valid),
        .frame_err(frame_err), .overrun(overrun), .err_count(err_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       o;
        logic       e;
        logic [7:0] c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: frame held as a list of received bits.
    logic       m_v, m_o, m_e, m_len;
    logic [7:0] m_d, m_c;
    logic [1:0] m_stq;
    logic       m_bits[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_v = 0; m_o = 0; m_e = 0; m_len = 0;
        m_d = 0; m_c = 0; m_stq = 0;
        m_bits.delete();
    endtask

    task automatic model_step(input logic [1:0] s, input logic rsh, input logic rx, input logic a);
        logic into0, good;
        exp_t e;
        m_e = 0;
        good = 0;
        if (m_stq == 2'd0 && s == 2'd1) begin
            m_bits.delete();
            m_len = 0;
        end else if (rsh && s != 2'd0) begin
            if (m_bits.size() < FB) m_bits.push_back(rx);
            else m_len = 1;
        end
        into0 = (s == 2'd0) && (m_stq != 2'd0);
        if (into0) begin
            if (m_stq == 2'd3)
                good = (m_bits.size() == FB) && (m_bits[0] == 1'b0) && (m_bits[FB-1] == 1'b1) && !m_len;
            if (good) begin
                if (m_v && !a) m_o = 1;
                for (int i = 0; i < 8; i++) m_d[i] = m_bits[i+1];
                m_v = 1;
            end else if (m_stq == 2'd3 || m_bits.size() != 0) begin
                m_e = 1;
                if (m_c != 8'hFF) m_c = m_c + 8'd1;
            end
        end
        if (!good && m_v && a) m_v = 0;
        if (into0) begin
            e.v = m_v; e.d = m_d; e.o = m_o; e.e = m_e; e.c = m_c;
            q.push_back(e);
        end
        m_stq = s;
    endtask

    task automatic cycle(input logic [1:0] s, input logic rsh, input logic rx, input logic a);
        st = s; RShift = rsh; rx_in = rx; data_ack = a;
        model_step(s, rsh, rx, a);
        @(posedge clk); #1;
    endtask

    task automatic chk_now(input string tag);
        check({tag, "_data_out"}, data_out, m_d);
        check({tag, "_data_valid"}, data_valid, m_v);
        check({tag, "_overrun"}, overrun, m_o);
        check({tag, "_err_count"}, err_count, m_c);
        check({tag, "_frame_err"}, frame_err, m_e);
        check({tag, "_busy"}, busy, st != 2'd0);
    endtask

    task automatic do_reset();
        rst = 1; st = 0; RShift = 0; rx_in = 0; data_ack = 0;
        model_reset();
        q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    function automatic logic [9:0] mk(input logic [7:0] d, input logic sb, input logic pb);
        return {pb, d, sb};
    endfunction

    // Frame: arm, np pulse/wait pairs, then back to idle. abort_at>=0 drops
    // to idle straight from the shift state before pulse abort_at.
    task automatic send_frame(input logic [9:0] bits, input int np, input logic ack_done, input int abort_at);
        logic b;
        cycle(2'd1, 0, 0, 0);
        for (int i = 0; i < np; i++) begin
            if (i == abort_at) begin
                cycle(2'd2, 0, 0, 0);
                cycle(2'd0, 0, 0, ack_done);
                cycle(2'd0, 0, 0, 0);
                return;
            end
            b = (i < FB) ? bits[i] : 1'b1;
            cycle(2'd2, 1'b1, b, 0);
            cycle(2'd3, 0, 0, 0);
        end
        cycle(2'd0, 0, 0, ack_done);
        cycle(2'd0, 0, 0, 0);
    endtask

    // Monitor: after each edge where the generator returned to idle, the
    // DUT's registered outputs are compared against the queued expectation.
    logic [1:0] st_h = 2'd0;
    logic       ev;
    initial begin
        forever begin
            @(posedge clk);
            ev = !rst && (st == 2'd0) && (st_h != 2'd0);
            st_h = rst ? 2'd0 : st;
            @(negedge clk);
            if (ev) begin
                if (q.size() == 0) begin
                    check("mon_queue_nonempty", 0, 1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("mon_data_valid", data_valid, e.v);
                    check("mon_data_out", data_out, e.d);
                    check("mon_overrun", overrun, e.o);
                    check("mon_frame_err", frame_err, e.e);
                    check("mon_err_count", err_count, e.c);
                end
            end else if (!rst) begin
                check("mon_frame_err_quiet", frame_err, 0);
            end
        end
    end

    initial begin
        do_reset();
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_err_count", err_count, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);

        // Good frame 0xA5
        send_frame(10'b11010_01010, 10, 0, -1);
        check("a5_data", data_out, 8'hA5);
        check("a5_valid", data_valid, 1);
        check("a5_errcnt", err_count, 0);
        chk_now("a5");

        // Ack, then 0x3C
        cycle(2'd0, 0, 0, 1);
        check("ack_valid_clear", data_valid, 0);
        send_frame(mk(8'h3C, 0, 1), 10, 0, -1);
        check("3c_data", data_out, 8'h3C);
        check("3c_valid", data_valid, 1);
        check("3c_overrun", overrun, 0);

        // Bad stop bit
        send_frame(mk(8'h5A, 0, 0), 10, 0, -1);
        check("badstop_errcnt", err_count, 1);
        check("badstop_data", data_out, 8'h3C);
        check("badstop_valid", data_valid, 1);
        chk_now("badstop");

        // Overrun
        cycle(2'd0, 0, 0, 1);
        send_frame(mk(8'h11, 0, 1), 10, 0, -1);
        check("ovr_first", overrun, 0);
        send_frame(mk(8'h22, 0, 1), 10, 0, -1);
        check("ovr_data", data_out, 8'h22);
        check("ovr_set", overrun, 1);
        send_frame(mk(8'h33, 0, 1), 10, 1, -1);
        check("ovr_sticky", overrun, 1);
        check("ovr_ack_valid", data_valid, 1);
        check("ovr_ack_data", data_out, 8'h33);

        // Short frame, then a full frame after a fresh start
        send_frame(mk(8'h00, 0, 1), 6, 0, -1);
        check("short_errcnt", err_count, 2);
        send_frame(mk(8'hFF, 0, 1), 10, 0, -1);
        check("ff_data", data_out, 8'hFF);
        check("ff_errcnt", err_count, 2);

        // Long frame (11 pulses) and aborts
        send_frame(mk(8'h77, 0, 1), 11, 0, -1);
        check("long_errcnt", err_count, 3);
        send_frame(mk(8'h77, 0, 1), 10, 0, 4);
        check("abort_errcnt", err_count, 4);
        send_frame(mk(8'h77, 0, 1), 10, 0, 0);
        check("abort_empty_errcnt", err_count, 4);
        chk_now("dir_end");

        // Randomized frames
        for (int n = 0; n < 150; n++) begin
            logic [7:0] d;
            logic sb, pb, ak;
            int np, ab;
            d  = 8'($urandom);
            sb = ($urandom_range(0, 7) == 0);
            pb = ($urandom_range(0, 7) != 0);
            np = ($urandom_range(0, 5) == 0) ? $urandom_range(8, 12) : 10;
            ak = 1'($urandom_range(0, 1));
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 9) : -1;
            send_frame(mk(d, sb, pb), np, ak, ab);
            cycle(2'd0, 0, 0, ($urandom_range(0, 2) == 0));
            chk_now("rnd");
        end

        // Reset mid-frame
        cycle(2'd1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(2'd2, 1, 1, 0);
            cycle(2'd3, 0, 0, 0);
        end
        do_reset();
        check("mrst_data_out", data_out, 0);
        check("mrst_valid", data_valid, 0);
        check("mrst_overrun", overrun, 0);
        check("mrst_errcnt", err_count, 0);
        check("mrst_frame_err", frame_err, 0);

        // Saturation
        for (int n = 0; n < 300; n++) send_frame(mk(8'h00, 0, 1), 1, 0, -1);
        check("sat_errcnt", err_count, 8'hFF);
        check("sat_valid", data_valid, 0);

        cycle(2'd0, 0, 0, 0);
        cycle(2'd0, 0, 0, 0);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
